// File: rtl/flux_fifo_bank.sv
// Tagged-write sink: steers {tag, data} words into per-flux circular queues and
// serves a single downstream reader that pops the lowest-indexed requested flux.
module flux_fifo_bank #(
    parameter int DATA_WIDTH = 8,
    parameter int FLUX       = 2,
    parameter int DEPTH      = 4,
    localparam int TAG_W     = $clog2(FLUX)
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [DATA_WIDTH+TAG_W-1:0] din,
    input  logic                        write,
    output logic [FLUX-1:0]             full,
    output logic [DATA_WIDTH+TAG_W-1:0] dout,
    output logic                        dout_valid,
    input  logic [FLUX-1:0]             read,
    output logic [FLUX-1:0]             empty,
    output logic [1:0]                  err
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [TAG_W-1:0]      wr_tag;
    logic [DATA_WIDTH-1:0] wr_data;
    logic                  tag_ok;

    assign {wr_tag, wr_data} = din;

    // Out-of-range tags can only exist when FLUX is not a power of two.
    generate
        if ((1 << TAG_W) == FLUX) begin : g_tag_pow2
            assign tag_ok = 1'b1;
        end else begin : g_tag_range
            assign tag_ok = ({1'b0, wr_tag} < (TAG_W + 1)'(FLUX));
        end
    endgenerate

    logic [TAG_W-1:0] sel;
    logic             sel_any;

    always_comb begin
        sel     = '0;
        sel_any = 1'b0;
        for (int f = FLUX - 1; f >= 0; f--) begin
            if (read[f]) begin
                sel     = TAG_W'(f);
                sel_any = 1'b1;
            end
        end
    end

    logic [FLUX-1:0]       wr_en;
    logic [FLUX-1:0]       pop;
    logic [FLUX-1:0]       ovf;
    logic [DATA_WIDTH-1:0] head_data [FLUX];

    genvar gi;
    generate
        for (gi = 0; gi < FLUX; gi++) begin : g_q
            logic [DATA_WIDTH-1:0] mem [DEPTH];
            logic [PTR_W-1:0]      wr_ptr_reg;
            logic [PTR_W-1:0]      rd_ptr_reg;
            logic [PTR_W-1:0]      wr_ptr_next;
            logic [PTR_W-1:0]      rd_ptr_next;
            logic [CNT_W-1:0]      count_reg;
            logic                  hit;

            assign full[gi]  = (count_reg == CNT_W'(DEPTH));
            assign empty[gi] = (count_reg == '0);

            // Flags come from the pre-edge count, so a same-cycle pop never rescues a write.
            assign hit       = write && !rst && tag_ok && (wr_tag == TAG_W'(gi));
            assign wr_en[gi] = hit && !full[gi];
            assign ovf[gi]   = hit && full[gi];
            assign pop[gi]   = !rst && sel_any && (sel == TAG_W'(gi)) && !empty[gi];

            assign wr_ptr_next = (wr_ptr_reg == PTR_W'(DEPTH - 1)) ? '0 : wr_ptr_reg + PTR_W'(1);
            assign rd_ptr_next = (rd_ptr_reg == PTR_W'(DEPTH - 1)) ? '0 : rd_ptr_reg + PTR_W'(1);

            assign head_data[gi] = mem[rd_ptr_reg];

            always_ff @(posedge clk) begin
                if (wr_en[gi]) begin
                    mem[wr_ptr_reg] <= wr_data;
                end
            end

            always_ff @(posedge clk) begin
                if (rst) begin
                    wr_ptr_reg <= '0;
                    rd_ptr_reg <= '0;
                    count_reg  <= '0;
                end else begin
                    if (wr_en[gi]) begin
                        wr_ptr_reg <= wr_ptr_next;
                    end
                    if (pop[gi]) begin
                        rd_ptr_reg <= rd_ptr_next;
                    end
                    case ({wr_en[gi], pop[gi]})
                        2'b10:   count_reg <= count_reg + CNT_W'(1);
                        2'b01:   count_reg <= count_reg - CNT_W'(1);
                        default: count_reg <= count_reg;
                    endcase
                end
            end
        end
    endgenerate

    logic [DATA_WIDTH+TAG_W-1:0] dout_reg;
    logic                        dout_valid_reg;
    logic [1:0]                  err_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            dout_reg       <= '0;
            dout_valid_reg <= 1'b0;
            err_reg        <= '0;
        end else begin
            dout_valid_reg <= |pop;
            if (|pop) begin
                dout_reg <= {sel, head_data[sel]};
            end
            if (|ovf) begin
                err_reg[0] <= 1'b1;
            end
            if (write && !tag_ok) begin
                err_reg[1] <= 1'b1;
            end
        end
    end

    assign dout       = dout_reg;
    assign dout_valid = dout_valid_reg;
    assign err        = err_reg;

endmodule

// File: tb/tb_flux_fifo_bank.sv
// Directed bench for flux_fifo_bank: stimulus pushes expected pops into a queue,
// a negedge monitor pops and compares every dout_valid pulse.
module tb_flux_fifo_bank;

    localparam int DW    = 8;
    localparam int FLUX  = 2;
    localparam int DEPTH = 4;
    localparam int TW    = 1;

    logic            clk = 1'b0;
    logic            rst;
    logic [DW+TW-1:0] din;
    logic            write;
    logic [FLUX-1:0] full;
    logic [DW+TW-1:0] dout;
    logic            dout_valid;
    logic [FLUX-1:0] read;
    logic [FLUX-1:0] empty;
    logic [1:0]      err;

    int n_cmp = 0;
    int n_bad = 0;
    logic [DW+TW-1:0] exp_q[$];

    flux_fifo_bank #(.DATA_WIDTH(DW), .FLUX(FLUX), .DEPTH(DEPTH)) dut (
        .clk        (clk),
        .rst        (rst),
        .din        (din),
        .write      (write),
        .full       (full),
        .dout       (dout),
        .dout_valid (dout_valid),
        .read       (read),
        .empty      (empty),
        .err        (err)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", name, act, req);
        end
    endtask

    // Monitor: every dout_valid pulse must match the oldest expected pop.
    always @(negedge clk) begin
        if (dout_valid === 1'b1) begin
            n_cmp++;
            if (exp_q.size() == 0) begin
                n_bad++;
                $display("FAIL pop_unexpected: got dout=%h, expected no pop", dout);
            end else begin
                logic [DW+TW-1:0] e;
                e = exp_q.pop_front();
                if (dout !== e) begin
                    n_bad++;
                    $display("FAIL pop_data: got dout=%h, expected %h", dout, e);
                end else begin
                    $display("pop  tag=%0d data=%h", dout[DW+TW-1:DW], dout[DW-1:0]);
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [TW-1:0] tag, input logic [DW-1:0] data);
        din   = {tag, data};
        write = 1'b1;
        step();
        write = 1'b0;
    endtask

    task automatic rd(input logic [FLUX-1:0] mask, input logic [TW-1:0] etag, input logic [DW-1:0] edata);
        exp_q.push_back({etag, edata});
        read = mask;
        step();
        read = '0;
    endtask

    // Same-cycle write and read; expected pop only when the caller says so.
    task automatic wr_rd(input logic [TW-1:0] tag, input logic [DW-1:0] data,
                         input logic [FLUX-1:0] mask, input logic expect_pop,
                         input logic [DW-1:0] edata);
        if (expect_pop) exp_q.push_back({tag, edata});
        din   = {tag, data};
        write = 1'b1;
        read  = mask;
        step();
        write = 1'b0;
        read  = '0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; din = '0; write = 1'b0; read = '0;
        step(); step();
        rst = 1'b0;
        step();

        // 1: reset state
        check("rst_empty", 32'(empty), 32'h3);
        check("rst_full", 32'(full), 32'h0);
        check("rst_dout", 32'(dout), 32'h0);
        check("rst_valid", 32'(dout_valid), 32'h0);
        check("rst_err", 32'(err), 32'h0);

        // 2: single token through flux 1
        wr(1'b1, 8'hA5);
        check("t2_empty_after_wr", 32'(empty), 32'h1);
        rd(2'b10, 1'b1, 8'hA5);
        check("t2_valid", 32'(dout_valid), 32'h1);
        check("t2_empty_after_rd", 32'(empty), 32'h3);
        step();

        // 3: overflow flux 0
        for (int i = 1; i <= 4; i++) wr(1'b0, 8'(i));
        check("t3_full", 32'(full), 32'h1);
        check("t3_err_before", 32'(err), 32'h0);
        wr(1'b0, 8'h05);
        check("t3_err_ovf", 32'(err), 32'h1);
        check("t3_full_hold", 32'(full), 32'h1);
        for (int i = 1; i <= 4; i++) rd(2'b01, 1'b0, 8'(i));
        check("t3_empty", 32'(empty), 32'h3);
        step();

        // 4: steady write+pop on flux 1 with pointer wrap
        wr(1'b1, 8'h10);
        wr(1'b1, 8'h11);
        for (int i = 0; i < 6; i++) begin
            wr_rd(1'b1, 8'h12 + 8'(i), 2'b10, 1'b1, 8'h10 + 8'(i));
            check("t4_not_empty", 32'(empty[1]), 32'h0);
            check("t4_not_full", 32'(full[1]), 32'h0);
        end
        rd(2'b10, 1'b1, 8'h16);
        check("t4_one_left", 32'(empty[1]), 32'h0);
        rd(2'b10, 1'b1, 8'h17);
        check("t4_drained", 32'(empty), 32'h3);
        check("t4_err_sticky", 32'(err), 32'h1);
        step();

        // 5: priority select and read of empty queue
        wr(1'b0, 8'h20);
        wr(1'b1, 8'h30);
        rd(2'b11, 1'b0, 8'h20);
        check("t5_flux1_kept", 32'(empty), 32'h1);
        read = 2'b01;
        step();
        read = '0;
        check("t5_empty_rd_valid", 32'(dout_valid), 32'h0);
        check("t5_empty_rd_dout", 32'(dout), 32'h020);
        check("t5_empty_rd_err", 32'(err), 32'h1);
        rd(2'b10, 1'b1, 8'h30);
        step();

        // write+pop on an empty queue: write lands, pop ignored
        wr_rd(1'b0, 8'h40, 2'b01, 1'b0, 8'h00);
        check("t5_wr_on_empty_valid", 32'(dout_valid), 32'h0);
        check("t5_wr_on_empty", 32'(empty), 32'h2);
        rd(2'b01, 1'b0, 8'h40);
        step();

        // write to full queue while popping it: write dropped, count drops to 3
        for (int i = 1; i <= 4; i++) wr(1'b0, 8'h40 + 8'(i));
        wr_rd(1'b0, 8'h45, 2'b01, 1'b1, 8'h41);
        check("t5_full_pop_drop", 32'(full), 32'h0);
        rd(2'b01, 1'b0, 8'h42);
        rd(2'b01, 1'b0, 8'h43);
        rd(2'b01, 1'b0, 8'h44);
        check("t5_drop_confirmed", 32'(empty), 32'h3);
        step();

        // 6: reset mid-stream
        for (int i = 0; i < 4; i++) begin
            wr(1'b0, 8'h50 + 8'(i));
            wr(1'b1, 8'h60 + 8'(i));
        end
        check("t6_both_full", 32'(full), 32'h3);
        din = {1'b1, 8'h55}; write = 1'b1; rst = 1'b1;
        step();
        write = 1'b0; rst = 1'b0;
        check("t6_empty", 32'(empty), 32'h3);
        check("t6_full", 32'(full), 32'h0);
        check("t6_err", 32'(err), 32'h0);
        check("t6_dout", 32'(dout), 32'h0);
        wr(1'b0, 8'h3C);
        rd(2'b01, 1'b0, 8'h3C);
        step();
        step();

        check("scoreboard_drained", 32'(exp_q.size()), 32'h0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
